// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the MEM-stage data-memory bus master.
package mem_bus_pkg;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  // Low address bits that must be zero for a word access
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when the byte offset addresses a whole word
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb & ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stage_bus_master_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Increment unless already saturated
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_stage_bus_master.sv
// MEM-stage bus master: turns EX/MEM load/store controls into a req/ack
// transaction on the data-memory bus and stalls the pipeline until it completes.
module mem_stage_bus_master
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_2,
  output logic              o_stall,
  output logic [DATA_W-1:0] o_load_data,
  output logic              o_addr_exc,
  output logic              o_bus_fault,
  output logic [CNT_W-1:0]  o_stall_cycles,
  output logic              o_bus_req,
  output logic              o_bus_we,
  output logic [ADDR_W-1:0] o_bus_addr,
  output logic [DATA_W-1:0] o_bus_wdata,
  input  logic              i_bus_ack,
  input  logic              i_bus_err,
  input  logic [DATA_W-1:0] i_bus_rdata
);

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(ALIGN_MASK);

  state_e state;
  state_e state_next;

  logic access;
  logic aligned;
  logic pending;
  logic misaligned;
  logic launch;
  logic complete;
  logic acked;

  // Decode the EX/MEM controls; a simultaneous read+write is a write
  assign access     = i_mem_read | i_mem_write;
  assign aligned    = is_aligned(i_addr[1:0]);
  assign pending    = access & aligned;
  assign misaligned = access & ~aligned;
  assign acked      = i_bus_ack & o_bus_req;

  // Next-state logic; DONE always returns to IDLE so nothing is reissued
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pending) state_next = REQ;
      REQ:     if (acked) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs and datapath strobes
  always_comb begin
    o_stall    = 1'b0;
    o_addr_exc = 1'b0;
    launch     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        o_stall    = pending;
        o_addr_exc = misaligned;
        launch     = pending;
      end
      REQ: begin
        o_stall  = 1'b1;
        complete = acked;
      end
      DONE:    ;
      default: ;
    endcase
  end

  // State register plus registered bus outputs and load-data capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_load_data <= '0;
      o_bus_fault <= 1'b0;
    end else begin
      state <= state_next;
      if (launch) begin
        o_bus_req   <= 1'b1;
        o_bus_we    <= i_mem_write;
        o_bus_addr  <= i_addr & WORD_MASK;
        o_bus_wdata <= i_data_2;
      end
      if (complete) begin
        o_bus_req   <= 1'b0;
        o_load_data <= (i_bus_err || o_bus_we) ? '0 : i_bus_rdata;
        if (i_bus_err) begin
          o_bus_fault <= 1'b1;
        end
      end
    end
  end

  // Performance counter of stalled cycles
  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (o_stall),
    .count(o_stall_cycles)
  );

endmodule

// File: tb/tb_mem_stage_bus_master.sv
// Self-checking bench for mem_stage_bus_master: table of accesses with a
// load-data scoreboard, plus a hand-written reset-during-REQ sequence.
`timescale 1ns/1ps
module tb_mem_stage_bus_master;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned CW  = 32;
  localparam int unsigned SCW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_mem_read, i_mem_write;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_data_2;
  logic          i_bus_ack, i_bus_err;
  logic [DW-1:0] i_bus_rdata;

  logic          o_stall, o_addr_exc, o_bus_fault, o_bus_req, o_bus_we;
  logic [DW-1:0] o_load_data, o_bus_wdata;
  logic [AW-1:0] o_bus_addr;
  logic [CW-1:0] o_stall_cycles;

  logic           s_stall, s_addr_exc, s_bus_fault, s_bus_req, s_bus_we;
  logic [DW-1:0]  s_load_data, s_bus_wdata;
  logic [AW-1:0]  s_bus_addr;
  logic [SCW-1:0] s_stall_cycles;

  always #5 clk = ~clk;

  mem_stage_bus_master #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_addr(i_addr), .i_data_2(i_data_2),
    .o_stall(o_stall), .o_load_data(o_load_data), .o_addr_exc(o_addr_exc),
    .o_bus_fault(o_bus_fault), .o_stall_cycles(o_stall_cycles),
    .o_bus_req(o_bus_req), .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
    .o_bus_wdata(o_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err), .i_bus_rdata(i_bus_rdata)
  );

  // Narrow-counter instance sharing all inputs, used to observe saturation
  mem_stage_bus_master #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(SCW)) dut_sat (
    .clk(clk), .reset(reset),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
    .i_addr(i_addr), .i_data_2(i_data_2),
    .o_stall(s_stall), .o_load_data(s_load_data), .o_addr_exc(s_addr_exc),
    .o_bus_fault(s_bus_fault), .o_stall_cycles(s_stall_cycles),
    .o_bus_req(s_bus_req), .o_bus_we(s_bus_we), .o_bus_addr(s_bus_addr),
    .o_bus_wdata(s_bus_wdata),
    .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err), .i_bus_rdata(i_bus_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    int          exp_stall;
    int          exp_exc;
    logic [31:0] exp_load;
    logic        exp_fault;
  } vec_t;

  vec_t        vecs[11];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          passed = 0;
  int          cum_stall = 0;
  logic [15:0] stall_hist = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Present one EX/MEM instruction, act as the bus, and check the outcome
  task automatic run_vec(input vec_t v, input string tag);
    int          stalls, excs, reqs, bad_bus, waits_left, sat_exp;
    bit          done;
    logic [31:0] exp_addr, exp_load;
    stalls = 0; excs = 0; reqs = 0; bad_bus = 0; done = 1'b0;
    waits_left = v.waits;
    exp_addr = v.addr & 32'hFFFF_FFFC;
    exp_q.push_back(v.exp_load);
    @(negedge clk);
    i_mem_read = v.rd; i_mem_write = v.wr; i_addr = v.addr; i_data_2 = v.wdata;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = $urandom;
      #1;
      stall_hist = {stall_hist[14:0], o_stall};
      if (o_stall) stalls++;
      if (o_addr_exc) excs++;
      if (o_bus_req) begin
        reqs++;
        if (o_bus_addr !== exp_addr || o_bus_we !== v.wr || o_bus_wdata !== v.wdata) bad_bus++;
        if (waits_left == 0) begin
          i_bus_ack = 1'b1; i_bus_err = v.err; i_bus_rdata = v.rdata;
        end else begin
          waits_left--;
        end
      end
      if (!o_stall) done = 1'b1;
    end
    if (!done) check($sformatf("%s timeout", tag), 64'd0, 64'd1);
    check($sformatf("%s stall_len", tag), 64'(stalls), 64'(v.exp_stall));
    check($sformatf("%s addr_exc", tag), 64'(excs), 64'(v.exp_exc));
    check($sformatf("%s req_cycles", tag), 64'(reqs), 64'(v.exp_exc != 0 ? 0 : v.waits + 1));
    check($sformatf("%s bus_stable", tag), 64'(bad_bus), 64'd0);
    exp_load = exp_q.pop_front();
    check($sformatf("%s load_data", tag), 64'(o_load_data), 64'(exp_load));
    check($sformatf("%s bus_fault", tag), 64'(o_bus_fault), 64'(v.exp_fault));
    cum_stall += v.exp_stall;
    check($sformatf("%s stall_cycles", tag), 64'(o_stall_cycles), 64'(cum_stall));
    sat_exp = (cum_stall > 3) ? 3 : cum_stall;
    check($sformatf("%s sat_cycles", tag), 64'(s_stall_cycles), 64'(sat_exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //            rd    wr    addr          wdata         w  err   rdata         st ex load          flt
    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        0, 1'b0, 32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0024, 32'h12345678, 3, 1'b0, 32'hCAFEF00D, 5, 0, 32'h0,        1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,        0, 1'b0, 32'h0,        0, 1, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0,        1, 1'b0, 32'hA5A5A5A5, 3, 0, 32'hA5A5A5A5, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0044, 32'h0,        1, 1'b0, 32'h0BADF00D, 3, 0, 32'h0BADF00D, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0022, 32'h55,       0, 1'b0, 32'h0,        0, 1, 32'h0BADF00D, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0000_0050, 32'h0,        2, 1'b1, 32'hFFFFFFFF, 4, 0, 32'h0,        1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0054, 32'h0,        0, 1'b0, 32'h11112222, 2, 0, 32'h11112222, 1'b1};
    vecs[8]  = '{1'b1, 1'b1, 32'h0000_0060, 32'h77778888, 0, 1'b0, 32'h99990000, 2, 0, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_0064, 32'h1,        0, 1'b1, 32'h44,       2, 0, 32'h0,        1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0068, 32'h0,        0, 1'b0, 32'h5A5A0001, 2, 0, 32'h5A5A0001, 1'b1};

    reset = 1'b1;
    i_mem_read = 1'b0; i_mem_write = 1'b0; i_addr = '0; i_data_2 = '0;
    i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = '0;
    #12;
    check("reset ctrl", 64'({o_stall, o_bus_req, o_bus_we, o_bus_fault, o_addr_exc}), 64'd0);
    check("reset data", 64'({o_load_data, o_bus_addr}), 64'd0);
    check("reset cnt", 64'(o_stall_cycles), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      if (i == 4) check("b2b stall_pattern", 64'(stall_hist[7:0]), 64'h00EE);
    end

    // Reset while the bus is two cycles into a wait, then a stray ack
    @(negedge clk);
    i_mem_read = 1'b1; i_mem_write = 1'b0; i_addr = 32'h70; i_data_2 = 32'h0;
    i_bus_ack = 1'b0;
    #1 check("midreq launch_stall", 64'(o_stall), 64'd1);
    @(negedge clk); #1 check("midreq req_up", 64'(o_bus_req), 64'd1);
    @(negedge clk); #1 check("midreq still_req", 64'(o_bus_req), 64'd1);
    #2;
    reset = 1'b1; i_mem_read = 1'b0;
    #1;
    check("midreq reset ctrl", 64'({o_stall, o_bus_req, o_bus_we, o_bus_fault, o_addr_exc}), 64'd0);
    check("midreq reset addr", 64'(o_bus_addr), 64'd0);
    check("midreq reset wdata_load", 64'({o_bus_wdata, o_load_data}), 64'd0);
    check("midreq reset cnt", 64'({s_stall_cycles, o_stall_cycles}), 64'd0);
    @(negedge clk);
    reset = 1'b0; i_bus_ack = 1'b1; i_bus_err = 1'b1; i_bus_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    i_bus_ack = 1'b0; i_bus_err = 1'b0;
    #1;
    check("late_ack ctrl", 64'({o_stall, o_bus_req, o_bus_fault}), 64'd0);
    check("late_ack load", 64'(o_load_data), 64'd0);
    check("late_ack cnt", 64'(o_stall_cycles), 64'd0);
    cum_stall = 0;
    v = '{1'b1, 1'b0, 32'h0000_0080, 32'h0, 0, 1'b0, 32'h0F0F0F0F, 2, 0, 32'h0F0F0F0F, 1'b0};
    run_vec(v, "post_reset");

    @(negedge clk);
    i_mem_read = 1'b0; i_mem_write = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
